// File: rtl/relu_maxpool_if.sv
// Stream bundle between the column accumulator, the ReLU/max-pool stage and the
// feature-map buffer writer. The slave modport is the stage's view of the bundle.
interface relu_maxpool_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              valid_i;
  logic              last_i;
  logic [DATA_W-1:0] data_i;
  logic              pool_en_i;
  logic              valid_o;
  logic              last_o;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;
  logic              err_o;
  logic              busy_o;

  modport master (
    output valid_i, last_i, data_i, pool_en_i,
    input  valid_o, last_o, data_o, addr_o, err_o, busy_o
  );

  modport slave (
    input  valid_i, last_i, data_i, pool_en_i,
    output valid_o, last_o, data_o, addr_o, err_o, busy_o
  );
endinterface

// File: rtl/relu_maxpool.sv
// ReLU on the signed conv stream, optional 2x2 max-pool over groups of 4 beats,
// registered output with a per-layer sequential write address.
module relu_maxpool #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  relu_maxpool_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        win_q, win_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [DATA_W-1:0] relu;
  logic              idle;
  logic              mode_eff;
  logic [ADDR_W-1:0] cnt_base;
  logic [1:0]        win_base;
  logic [DATA_W-1:0] cur_max;
  logic              emit;
  logic [DATA_W-1:0] emit_data;

  assign relu = bus.data_i[DATA_W-1] ? '0 : bus.data_i;
  assign idle = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    emit      = 1'b0;
    emit_data = '0;
    // A beat arriving in S_IDLE starts a fresh layer: mode, window and address
    // come from this beat rather than from leftover registers.
    mode_eff  = idle ? bus.pool_en_i : mode_q;
    cnt_base  = idle ? '0 : cnt_q;
    win_base  = idle ? 2'd0 : win_q;
    cur_max   = ((win_base == 2'd0) || (relu > max_q)) ? relu : max_q;

    if (bus.valid_i) begin
      if (idle) begin
        mode_d = bus.pool_en_i;
        err_d  = 1'b0;
      end

      if (!mode_eff) begin
        emit      = 1'b1;
        emit_data = relu;
      end else begin
        max_d = cur_max;
        if ((win_base == 2'd3) || bus.last_i) begin
          emit      = 1'b1;
          emit_data = cur_max;
          win_d     = 2'd0;
          if (bus.last_i && (win_base != 2'd3)) begin
            err_d = 1'b1;
          end
        end else begin
          win_d = win_base + 2'd1;
        end
      end

      if (emit) begin
        valid_d = 1'b1;
        last_d  = bus.last_i;
        data_d  = emit_data;
        addr_d  = cnt_base;
        cnt_d   = bus.last_i ? '0 : cnt_base + ADDR_W'(1);
      end

      if (idle && !bus.last_i) begin
        state_d = S_RUN;
      end else if (!idle && bus.last_i) begin
        state_d = S_IDLE;
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.data_o  = data_q;
  assign bus.addr_o  = addr_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state_q == S_RUN);

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: expected outputs are queued as beats are driven
// and popped when the stage emits a result one cycle later.
module tb_relu_maxpool;
  logic clk;
  logic rst_n;

  relu_maxpool_if #(.DATA_W(8), .ADDR_W(10)) bus ();

  relu_maxpool #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] a;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; then compare whatever the stage produced against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("valid_o", 32'(bus.valid_o), 32'd1);
      if (bus.valid_o === 1'b1) begin
        chk("data_o", 32'(bus.data_o), 32'(e.d));
        chk("addr_o", 32'(bus.addr_o), 32'(e.a));
        chk("last_o", 32'(bus.last_o), 32'(e.l));
      end
    end else begin
      chk("no_output", 32'(bus.valid_o), 32'd0);
      chk("no_last", 32'(bus.last_o), 32'd0);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic pe,
                      input logic ev, input logic [7:0] ed, input logic [9:0] ea);
    exp_t e;
    bus.valid_i   = 1'b1;
    bus.last_i    = l;
    bus.data_i    = d;
    bus.pool_en_i = pe;
    if (ev) begin
      e.d = ed;
      e.a = ea;
      e.l = l;
      sb.push_back(e);
    end
    tick();
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.valid_i   = 1'b0;
    bus.last_i    = 1'b0;
    bus.data_i    = '0;
    bus.pool_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Bypass: -5,0,7,127,-128
    beat(8'hFB, 1'b0, 1'b0, 1'b1, 8'd0,   10'd0);
    chk("busy_run", 32'(bus.busy_o), 32'd1);
    beat(8'h00, 1'b0, 1'b0, 1'b1, 8'd0,   10'd1);
    beat(8'h07, 1'b0, 1'b0, 1'b1, 8'd7,   10'd2);
    beat(8'h7F, 1'b0, 1'b0, 1'b1, 8'd127, 10'd3);
    beat(8'h80, 1'b1, 1'b0, 1'b1, 8'd0,   10'd4);
    chk("busy_after_bypass", 32'(bus.busy_o), 32'd0);
    idle(2);

    // Single window: 3,-2,9,4
    beat(8'd3,  1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'hFE, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd9,  1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd4,  1'b1, 1'b1, 1'b1, 8'd9, 10'd0);
    chk("err_single", 32'(bus.err_o), 32'd0);
    idle(1);
    chk("hold_data", 32'(bus.data_o), 32'd9);
    chk("hold_addr", 32'(bus.addr_o), 32'd0);

    // 4x4 ofmap pooled, with input gaps
    beat(8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    idle(1);
    beat(8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    idle(2);
    beat(8'd4, 1'b0, 1'b1, 1'b1, 8'd4, 10'd0);
    for (int i = 0; i < 3; i++) beat(8'hFF, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'hFF, 1'b0, 1'b1, 1'b1, 8'd0, 10'd1);
    beat(8'h7F, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    idle(1);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'h80, 1'b0, 1'b1, 1'b1, 8'd127, 10'd2);
    beat(8'd5,  1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd50, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd6,  1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd7,  1'b1, 1'b1, 1'b1, 8'd50, 10'd3);
    chk("err_4x4", 32'(bus.err_o), 32'd0);
    idle(1);

    // Early last: 10,20
    beat(8'd10, 1'b0, 1'b1, 1'b0, 8'd0,  10'd0);
    beat(8'd20, 1'b1, 1'b1, 1'b1, 8'd20, 10'd0);
    chk("err_set", 32'(bus.err_o), 32'd1);
    idle(2);
    chk("err_sticky", 32'(bus.err_o), 32'd1);
    beat(8'd3,  1'b0, 1'b0, 1'b1, 8'd3, 10'd0);
    chk("err_cleared", 32'(bus.err_o), 32'd0);
    beat(8'hFF, 1'b1, 1'b0, 1'b1, 8'd0, 10'd1);
    idle(1);

    // Mode latch, then back-to-back bypass layer
    beat(8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd6, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
    beat(8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
    beat(8'd5, 1'b1, 1'b0, 1'b1, 8'd6, 10'd0);
    beat(8'd9, 1'b0, 1'b0, 1'b1, 8'd9, 10'd0);
    beat(8'd8, 1'b1, 1'b0, 1'b1, 8'd8, 10'd1);
    idle(1);

    // Reset mid-window
    beat(8'd50, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd60, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    rst_n = 1'b1;
    beat(8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
    beat(8'd8, 1'b1, 1'b1, 1'b1, 8'd8, 10'd0);
    idle(1);

    // Address wrap in bypass: 1025 beats, addr 1023 -> 0 on the final one
    for (int i = 0; i < 1025; i++)
      beat(8'(i % 100), (i == 1024), 1'b0, 1'b1, 8'(i % 100), 10'(i));
    chk("err_wrap", 32'(bus.err_o), 32'd0);
    idle(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Stage directly downstream of the per-column accumulator. It consumes that block's saturated 8-bit convolution stream (valid/last/data) and applies ReLU.
- Optionally reduces each group of 4 consecutive beats (one 2x2 pooling window, as the accumulator emits them in pool order) to a single maximum.
- Produces a registered output stream with a sequential write address for the feature-map buffer feeding the next layer.

Parameters:
DATA_W, 8, width of input/output activation (signed in, non-negative out)
ADDR_W, 10, width of output address counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
valid_i  input  1  input beat qualifier; no backpressure, every valid beat must be consumed
last_i  input  1  final beat of layer, qualified by valid_i
data_i  input  DATA_W  signed conv result
pool_en_i  input  1  1 = 2x2 max-pool mode, 0 = ReLU-only bypass; sampled on first beat of layer
valid_o  output  1  output beat qualifier, single-cycle pulse per result
last_o  output  1  final output of layer, asserted with valid_o
data_o  output  DATA_W  ReLU/pooled result, range 0..127
addr_o  output  ADDR_W  output index within layer, valid with valid_o
err_o  output  1  sticky: layer ended mid-window
busy_o  output  1  high while in S_RUN

Behaviour:
- Reset: all outputs 0; state S_IDLE; win_cnt=0, max_r=0, out_cnt=0, mode_r=0, err_o=0. Reset mid-layer discards the partial window and emits nothing.
- ReLU: relu = data_i[DATA_W-1] ? 0 : data_i. Examples: -128 -> 0, 127 -> 127.
- FSM S_IDLE:
  - valid_i latches mode_r=pool_en_i, clears err_o and out_cnt, and processes the beat as beat 0.
  - Goes to S_RUN unless last_i is also high; in that case the beat is processed and the FSM stays in S_IDLE.
- FSM S_RUN:
  - Each valid_i beat is processed.
  - valid_i&last_i: the beat is processed, then the FSM returns to S_IDLE.
  - pool_en_i changes during S_RUN are ignored.
- Bypass (mode_r=0):
  - Each valid beat produces an output on the next cycle: valid_o=1, data_o=relu, addr_o=out_cnt. out_cnt then increments.
  - last_o = registered last_i.
- Pool mode (mode_r=1):
  - win_cnt counts 0..3.
  - Beat with win_cnt=0: max_r<=relu.
  - Other beats: max_r<=max(max_r, relu), unsigned compare.
  - Beat with win_cnt=3: the next cycle gives valid_o=1, data_o=max(max_r, relu), addr_o=out_cnt. win_cnt wraps to 0 and out_cnt increments.
  - Latency is 1 cycle from the 4th beat.
- Early last in pool mode (last_i with win_cnt!=3):
  - Emits the partial maximum next cycle with valid_o=1, last_o=1.
  - Sets err_o=1 and resets win_cnt=0.
  - err_o holds until the first beat of the next layer.
- last_o is asserted only together with valid_o. On the final output, out_cnt and win_cnt return to 0.
- out_cnt wraps 2^ADDR_W-1 -> 0 silently; no error is flagged.
- valid_i low: no state change; outputs drop to valid_o=0, last_o=0; data_o/addr_o hold their last values.
- Back-to-back layers: a valid beat in the cycle after last_i is accepted as beat 0 of the new layer, with no bubble.
- busy_o = (state==S_RUN).

Test Plan:
- Bypass: pool_en_i=0, beats -5,0,7,127,-128 (last on -128) -> outputs 0,0,7,127,0 at addr 0..4, each 1 cycle after input; last_o on addr 4; busy_o low afterwards.
- Single window: pool_en_i=1, beats 3,-2,9,4 (last on 4) -> one output data_o=9, addr_o=0, last_o=1, 1 cycle after the 4th beat; err_o=0.
- 4x4 ofmap pooled: 16 beats in 4 windows {1,2,3,4},{-1,-1,-1,-1},{127,0,0,-128},{5,50,6,7} -> data 4,0,127,50 at addr 0..3; last_o only on addr 3; gaps in valid_i do not change results.
- Early last: pool_en_i=1, beats 10,20 with last on 20 -> data_o=20, last_o=1, err_o=1. The next layer's first beat clears err_o, and its addr_o restarts at 0.
- Mode latch / back-to-back: pool_en_i toggled to 0 after beat 0 of a pooled layer -> the layer still pools. A new layer starting the cycle after last_i with pool_en_i=0 -> bypass, addr_o from 0.
- Reset mid-window: 2 beats, then rst_n=0 for 1 cycle, then 4 beats 1,2,3,8 with last -> single output 8 at addr 0; no output from the discarded partial window.
